input_buffer_sched: RTL and testbench

Read/write scheduler for the input buffer dual-port RAM. It accepts a valid/ready word stream from the loader and writes it into the buffer as a circular FIFO. On command it issues fixed-length read bursts to the MAC array. It owns all pointer, occupancy and address generation, so the buffer itself never sees an out-of-range or colliding access.

---
 rtl/input_buffer_sched.sv | 133 +++++++++++++
 tb/tb_input_buffer_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_sched.sv
// input_buffer_sched: write/read scheduler for the input-buffer dual-port RAM.
// The loader stream fills the buffer as a circular FIFO. On start, a
// fixed-length read burst is issued to the MAC array.
// Optional feature macro: INBUF_SCHED_REPLAY_EN. When it is defined, a burst
// with keep=1 reads the window without freeing it, so the window can be replayed.
module input_buffer_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          burst_len,
  input  logic                         keep,
  output logic                         busy,
  output logic                         done,
  output logic                         err_start,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         buf_wr_en,
  output logic [ADDR_WIDTH-1:0]        buf_wr_addr,
  output logic [DATA_WIDTH-1:0]        buf_wr_data,
  output logic                         buf_rd_en,
  output logic [ADDR_WIDTH-1:0]        buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]        buf_rd_data,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         full,
  output logic                         empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, idx;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  keep_q;
  logic                  vld_q;
  logic                  accept, pop, start_ok;

  assign full      = (count == DEPTH_W);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign accept    = in_valid & in_ready;

  assign buf_wr_en   = accept;
  assign buf_wr_addr = wr_ptr;
  assign buf_wr_data = accept ? in_data : '0;

  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN);
  assign buf_rd_en = (state == BURST);
  assign pop       = buf_rd_en & !keep_q;

  // The start check uses the count at the sampling edge. A word written in
  // that same cycle is not yet visible, so a burst never overruns the data.
  assign start_ok  = (burst_len != '0) && (burst_len <= count);

  assign out_valid = vld_q;
  assign out_data  = vld_q ? buf_rd_data : '0;

`ifdef INBUF_SCHED_REPLAY_EN
  // A replay burst walks forward from the head and leaves rd_ptr in place.
  assign buf_rd_addr = keep_q ? rd_ptr + idx : rd_ptr;

  // keep is captured only when a burst is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 keep_q <= 1'b0;
    else if (state == IDLE && start && start_ok) keep_q <= keep;
  end
`else
  logic unused_keep;
  assign unused_keep = keep;
  assign keep_q      = 1'b0;
  assign buf_rd_addr = rd_ptr;
`endif

  // Burst sequencing: IDLE -> BURST for len cycles -> DRAIN for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      idx       <= '0;
      err_start <= 1'b0;
    end else begin
      err_start <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (start_ok) begin
            len_q <= burst_len;
            idx   <= '0;
            state <= BURST;
          end else begin
            err_start <= 1'b1;
          end
        end
        BURST: begin
          idx <= idx + 1'b1;
          if ({1'b0, idx} == len_q - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pointers and occupancy. A write and a pop in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{ADDR_WIDTH{1'b0}}, accept} - {{ADDR_WIDTH{1'b0}}, pop};
    end
  end

  // The RAM has one cycle of read latency, so out_valid trails the read enable by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= buf_rd_en;
  end

endmodule

// File: tb/tb_input_buffer_sched.sv
// Scoreboard bench for input_buffer_sched with DEPTH=8. A behavioural RAM
// model sits on the buffer ports. The stimulus pushes the expected writes,
// read addresses and burst data. A negedge monitor pops and compares them.
module tb_input_buffer_sched;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready;
  logic signed [DW-1:0] in_data;
  logic                 start, keep;
  logic [AW:0]          burst_len;
  logic                 busy, done, err_start, out_valid;
  logic signed [DW-1:0] out_data;
  logic                 buf_wr_en, buf_rd_en;
  logic [AW-1:0]        buf_wr_addr, buf_rd_addr;
  logic [DW-1:0]        buf_wr_data, buf_rd_data;
  logic [AW:0]          count;
  logic                 full, empty;

  input_buffer_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .burst_len(burst_len), .keep(keep),
    .busy(busy), .done(done), .err_start(err_start), .out_valid(out_valid),
    .out_data(out_data), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // RAM model with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  logic [AW-1:0] ra_q [$];
  logic [DW-1:0] rd_q [$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  // Monitor: compare every buffer access and every burst word against the queues.
  always @(negedge clk) begin
    if (buf_wr_en) begin
      if (wa_q.size() == 0) chk("unexpected_write", 32'(buf_wr_addr), 32'hFFFF_FFFF);
      else begin
        chk("wr_addr", 32'(buf_wr_addr), 32'(wa_q.pop_front()));
        chk("wr_data", 32'(buf_wr_data), 32'(wd_q.pop_front()));
      end
    end
    if (buf_rd_en) begin
      if (ra_q.size() == 0) chk("unexpected_read", 32'(buf_rd_addr), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(buf_rd_addr), 32'(ra_q.pop_front()));
    end
    if (out_valid) begin
      if (rd_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
      else chk("out_data", 32'(out_data), 32'(rd_q.pop_front()));
    end
    if (done) done_seen++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input int first, input int n, input int addr0);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = DW'(first + i);
      wa_q.push_back(AW'((addr0 + i) % DEPTH));
      wd_q.push_back(DW'(first + i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Caller pushes the expected data. The task pushes addresses base..base+len-1 and checks the frame timing.
  task automatic run_burst(input int len, input bit kp, input int base, input int exp_cnt, input bit hold);
    for (int i = 0; i < len; i++) ra_q.push_back(AW'((base + i) % DEPTH));
    start = 1'b1; burst_len = (AW+1)'(len); keep = kp;
    tick();
    start = 1'b0; burst_len = '0; keep = 1'b0;
    chk("busy_on", 32'(busy), 1);
    for (int c = 0; c < len; c++) begin
      if (hold) chk("cnt_hold", 32'(count), 32'(exp_cnt));
      tick();
    end
    chk("done_pulse", 32'(done), 1);
    chk("last_valid", 32'(out_valid), 1);
    tick();
    chk("done_clear", 32'(done), 0);
    chk("busy_off", 32'(busy), 0);
    chk("cnt_after", 32'(count), 32'(exp_cnt));
  endtask

  task automatic bad_start(input int len);
    start = 1'b1; burst_len = (AW+1)'(len);
    tick();
    start = 1'b0; burst_len = '0;
    chk("err_pulse", 32'(err_start), 1);
    chk("err_busy", 32'(busy), 0);
    tick();
    chk("err_clear", 32'(err_start), 0);
    chk("err_cnt", 32'(count), 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int dsnap;
    bit kp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; keep = 1'b0; burst_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_wr_en", 32'(buf_wr_en), 0);
    chk("rst_rd_en", 32'(buf_rd_en), 0);
    chk("rst_addrs", {buf_wr_addr, buf_rd_addr}, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {empty, full, done, err_start}, 32'b1000);
    tick();
    rst = 1'b0;

    // Write four words, then pop them in one burst.
    wr_burst(32'h11, 4, 0);
    chk("cnt4", 32'(count), 4);
    chk("not_empty", 32'(empty), 0);
    for (int i = 0; i < 4; i++) rd_q.push_back(DW'(32'h11 + i));
    run_burst(4, 1'b0, 0, 0, 1'b0);
    chk("empty_again", 32'(empty), 1);

    // Fill from a clean reset, block on full, then pop one and wrap the write pointer.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    wr_burst(32'h20, 8, 0);
    chk("full", 32'(full), 1);
    chk("in_ready_low", 32'(in_ready), 0);
    chk("cnt8", 32'(count), 8);
    in_valid = 1'b1; in_data = 16'h0099;
    chk("no_wr_full", 32'(buf_wr_en), 0);
    tick();
    in_valid = 1'b0;
    rd_q.push_back(16'h0020); ra_q.push_back(3'd0);
    start = 1'b1; burst_len = 4'd1;
    tick();
    start = 1'b0; burst_len = '0;
    chk("ready_still_low", 32'(in_ready), 0);
    tick();
    chk("ready_back", 32'(in_ready), 1);
    chk("cnt7", 32'(count), 7);
    wr_burst(32'h30, 1, 0);
    chk("cnt8_wrap", 32'(count), 8);

    // Pop five, leaving three entries. Then issue two rejected starts.
    for (int i = 1; i <= 5; i++) rd_q.push_back(DW'(32'h20 + i));
    run_burst(5, 1'b0, 1, 3, 1'b0);
    bad_start(5);
    bad_start(0);

`ifdef INBUF_SCHED_REPLAY_EN
    // Read the same window twice without consuming it.
    for (int r = 0; r < 2; r++) begin
      rd_q.push_back(16'h0026); rd_q.push_back(16'h0027); rd_q.push_back(16'h0030);
      run_burst(3, 1'b1, 6, 3, 1'b1);
    end
    kp = 1'b0;
`else
    kp = 1'b1;
`endif
    // Consuming burst of three with two writes in flight; kp=1 is ignored when replay is off.
    // A start during the burst must be ignored.
    ra_q.push_back(3'd6); ra_q.push_back(3'd7); ra_q.push_back(3'd0);
    rd_q.push_back(16'h0026); rd_q.push_back(16'h0027); rd_q.push_back(16'h0030);
    start = 1'b1; burst_len = 4'd3; keep = kp;
    tick();
    keep = 1'b0; burst_len = 4'd1;
    in_valid = 1'b1; in_data = 16'h0040; wa_q.push_back(3'd1); wd_q.push_back(16'h0040);
    tick();
    start = 1'b0; burst_len = '0;
    chk("no_err_busy", 32'(err_start), 0);
    in_data = 16'h0041; wa_q.push_back(3'd2); wd_q.push_back(16'h0041);
    tick();
    in_valid = 1'b0;
    chk("cnt_mixed", 32'(count), 3);
    tick();
    chk("mixed_done", 32'(done), 1);
    tick();
    chk("cnt_mixed_end", 32'(count), 2);
    rd_q.push_back(16'h0040); rd_q.push_back(16'h0041);
    run_burst(2, 1'b0, 1, 0, 1'b0);

    // Assert reset in cycle 2 of an 8-word burst.
    wr_burst(32'h50, 8, 3);
    ra_q.push_back(3'd3);
    start = 1'b1; burst_len = 4'd8;
    tick();
    start = 1'b0; burst_len = '0;
    tick();
    dsnap = done_seen;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_rd_en", 32'(buf_rd_en), 0);
    chk("abort_count", 32'(count), 0);
    chk("abort_flags", {empty, full, in_ready}, 32'b101);
    chk("abort_addrs", {buf_wr_addr, buf_rd_addr}, 0);
    tick(); tick();
    chk("abort_no_done", 32'(done_seen), 32'(dsnap));
    rst = 1'b0;
    tick();

    chk("wq_drained", 32'(wa_q.size()), 0);
    chk("raq_drained", 32'(ra_q.size()), 0);
    chk("rdq_drained", 32'(rd_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
